game_sequencer: RTL and testbench

Top-level game controller for the Flappy Bird design. It sequences the pipe datapath: holds it in reset while idle, enables it during play, and supplies a fresh pseudo-random `pipe_length` each time a pipe leaves the screen. It also detects bird/pipe and bird/floor collisions and keeps the current and high scores. It sits between the debounced user input and the `pipes` and bird modules, and drives the game-state outputs used by the VGA and HEX display logic.

---
 rtl/game_pkg.sv | 14 +
 rtl/lfsr10.sv | 24 ++
 rtl/game_sequencer.sv | 123 ++++++++++++
 tb/tb_game_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the Flappy Bird game controller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam logic [9:0] LFSR_SEED = 10'h2A5;
    localparam int         SCREEN_W  = 640;
    localparam int         SCREEN_H  = 480;

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1), free-running, self-recovering from the all-zero lockup.
module lfsr10 #(
    parameter logic [9:0] SEED = game_pkg::LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] out
);

    logic [9:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else if (q == '0) begin
            q <= SEED;
        end else begin
            q <= {q[8:0], q[9] ^ q[6]};
        end
    end

    assign out = q;

endmodule

// File: rtl/game_sequencer.sv
// Flappy Bird game controller: sequences the pipe datapath, detects collisions,
// supplies random pipe gaps and keeps current/high score.
module game_sequencer #(
    parameter int         N         = 10,
    parameter int         BIRD_X    = 100,
    parameter int         BIRD_SIZE = 15,
    parameter int         SCREEN_H  = 480,
    parameter int         SCORE_W   = 8,
    parameter logic [9:0] LFSR_SEED = game_pkg::LFSR_SEED
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flap,
    input  logic [N-1:0]       bird_y,
    input  logic [N-1:0]       pipe_x,
    input  logic [N-1:0]       pipe_y0,
    input  logic [N-1:0]       pipe_y1,
    output logic               pipe_rst,
    output logic               pipe_start,
    output logic [9:0]         pipe_length,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    import game_pkg::game_state_t;
    import game_pkg::IDLE;
    import game_pkg::PLAY;
    import game_pkg::OVER;

    localparam logic [N:0] BIRD_L = (N+1)'(BIRD_X);
    localparam logic [N:0] BIRD_R = (N+1)'(BIRD_X + BIRD_SIZE);
    localparam logic [N:0] FLOOR  = (N+1)'(SCREEN_H);

    game_state_t  state_q;
    game_state_t  state_d;
    logic [N-1:0] pipe_x_q;
    logic [9:0]   lfsr_val;
    logic         load_len;
    logic         score_inc;
    logic         score_clr;
    logic         wrap;
    logic         overlap;
    logic         floor_hit;
    logic         collide;
    logic [N:0]   bird_bot;

    lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .out   (lfsr_val)
    );

    // Extra MSB keeps bird_y + BIRD_SIZE from wrapping near the bottom of the range.
    assign bird_bot  = {1'b0, bird_y} + (N+1)'(BIRD_SIZE);
    assign overlap   = ({1'b0, pipe_x} <= BIRD_R) && ({1'b0, pipe_x} >= BIRD_L) &&
                       (({1'b0, bird_y} < {1'b0, pipe_y1}) || (bird_bot > {1'b0, pipe_y0}));
    assign floor_hit = (bird_bot >= FLOOR);
    assign collide   = overlap || floor_hit;

    // pipe_x dwells at 0 for many cycles; only the first zero sample counts as a wrap.
    assign wrap = (state_q == PLAY) && (pipe_x == '0) && (pipe_x_q != '0);

    always_comb begin
        state_d   = state_q;
        load_len  = 1'b0;
        score_inc = 1'b0;
        score_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (flap) begin
                    state_d  = PLAY;
                    load_len = 1'b1;
                end
            end
            PLAY: begin
                if (collide) begin
                    state_d = OVER;
                end else if (wrap) begin
                    load_len  = 1'b1;
                    score_inc = 1'b1;
                end
            end
            OVER: begin
                if (flap) begin
                    state_d   = IDLE;
                    score_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pipe_x_q    <= '0;
            pipe_length <= '0;
            score       <= '0;
            high_score  <= '0;
        end else begin
            state_q  <= state_d;
            pipe_x_q <= pipe_x;
            if (load_len) begin
                pipe_length <= lfsr_val;
            end
            if (score_clr) begin
                score <= '0;
            end else if (score_inc && (score != '1)) begin
                score <= score + 1'b1;
            end
            if (score > high_score) begin
                high_score <= score;
            end
        end
    end

    // Outputs decode directly from the state register, so they change only on clock edges.
    assign pipe_rst   = (state_q != PLAY) && (state_q != OVER);
    assign pipe_start = (state_q == PLAY);
    assign state      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus pushes expected outputs, a negedge monitor compares.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       flap;
    logic [9:0] bird_y;
    logic [9:0] pipe_x;
    logic [9:0] pipe_y0;
    logic [9:0] pipe_y1;
    logic       pipe_rst;
    logic       pipe_start;
    logic [9:0] pipe_length;
    logic [1:0] state;
    logic [7:0] score;
    logic [7:0] high_score;

    game_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .flap        (flap),
        .bird_y      (bird_y),
        .pipe_x      (pipe_x),
        .pipe_y0     (pipe_y0),
        .pipe_y1     (pipe_y1),
        .pipe_rst    (pipe_rst),
        .pipe_start  (pipe_start),
        .pipe_length (pipe_length),
        .state       (state),
        .score       (score),
        .high_score  (high_score)
    );

    always #10 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       prst;
        logic       pstart;
        logic [7:0] sc;
        logic [7:0] hs;
        logic [9:0] len;
        bit         chk_len;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference LFSR x^10 + x^7 + 1, used only to predict pipe_length loads.
    logic [9:0] lfsr_m;
    always @(posedge clk or negedge reset) begin
        if (!reset) lfsr_m <= 10'h2A5;
        else        lfsr_m <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    end

    task automatic expect_out(input string nm, input logic [1:0] st, input logic prst,
                              input logic pstart, input logic [7:0] sc, input logic [7:0] hs,
                              input logic [9:0] len, input bit chk_len);
        exp_t x;
        x.name = nm; x.st = st; x.prst = prst; x.pstart = pstart;
        x.sc = sc; x.hs = hs; x.len = len; x.chk_len = chk_len;
        sb.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (state === e.st && pipe_rst === e.prst && pipe_start === e.pstart &&
                score === e.sc && high_score === e.hs &&
                (!e.chk_len || pipe_length === e.len)) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got st=%0d rst=%0d start=%0d score=%0d hs=%0d len=%h, expected st=%0d rst=%0d start=%0d score=%0d hs=%0d len=%h (len checked=%0d)",
                         e.name, state, pipe_rst, pipe_start, score, high_score, pipe_length,
                         e.st, e.prst, e.pstart, e.sc, e.hs, e.len, e.chk_len);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit         seen [0:1023];
    logic [9:0] v0;
    logic [9:0] v;
    int         distinct;
    logic [9:0] len1, len2, len3;

    initial begin
        reset   = 1'b0;
        flap    = 1'b0;
        bird_y  = 10'd200;
        pipe_x  = 10'd640;
        pipe_y0 = 10'd1000;
        pipe_y1 = 10'd0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        expect_out("reset", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0, 10'h000, 1'b1);
        chk("lfsr_seed", 32'(dut.u_lfsr.out), 32'h2A5);
        step();
        chk("lfsr_first_step", 32'(dut.u_lfsr.out), 32'h14B);

        distinct = 0;
        @(negedge clk);
        v0 = dut.u_lfsr.out;
        v  = v0;
        for (int i = 0; i < 1023; i++) begin
            if (v != 10'h000 && !seen[v]) distinct++;
            seen[v] = 1'b1;
            @(negedge clk);
            v = dut.u_lfsr.out;
        end
        chk("lfsr_distinct", 32'(distinct), 32'd1023);
        chk("lfsr_period", 32'(v), 32'(v0));
        step();

        len1 = lfsr_m;
        flap = 1'b1; step(); flap = 1'b0;
        expect_out("start", 2'd1, 1'b0, 1'b1, 8'd0, 8'd0, len1, 1'b1);
        flap = 1'b1; step(); flap = 1'b0;
        expect_out("flap_in_play", 2'd1, 1'b0, 1'b1, 8'd0, 8'd0, len1, 1'b1);

        pipe_x = 10'd3; step();
        pipe_x = 10'd2; step();
        pipe_x = 10'd1; step();
        pipe_x = 10'd0; len2 = lfsr_m; step();
        expect_out("wrap_first", 2'd1, 1'b0, 1'b1, 8'd1, 8'd0, len2, 1'b1);
        step(10);
        expect_out("wrap_dwell", 2'd1, 1'b0, 1'b1, 8'd1, 8'd1, len2, 1'b1);
        step(9);
        pipe_x = 10'd640; step();
        expect_out("wrap_exit", 2'd1, 1'b0, 1'b1, 8'd1, 8'd1, len2, 1'b1);

        pipe_x = 10'd105; pipe_y1 = 10'd200; pipe_y0 = 10'd260; bird_y = 10'd220; step();
        expect_out("gap_no_collide", 2'd1, 1'b0, 1'b1, 8'd1, 8'd1, len2, 1'b1);
        bird_y = 10'd190; step();
        expect_out("pipe_collide", 2'd2, 1'b0, 1'b0, 8'd1, 8'd1, len2, 1'b1);
        step();
        expect_out("over_hold", 2'd2, 1'b0, 1'b0, 8'd1, 8'd1, len2, 1'b1);

        pipe_x = 10'd640; bird_y = 10'd200;
        flap = 1'b1; step(); flap = 1'b0;
        expect_out("restart", 2'd0, 1'b1, 1'b0, 8'd0, 8'd1, len2, 1'b1);

        len3 = lfsr_m;
        flap = 1'b1; step(); flap = 1'b0;
        expect_out("start2", 2'd1, 1'b0, 1'b1, 8'd0, 8'd1, len3, 1'b1);

        for (int i = 0; i < 256; i++) begin
            pipe_x = 10'd1; step();
            pipe_x = 10'd0; step();
            if (i == 0)   expect_out("score_1", 2'd1, 1'b0, 1'b1, 8'd1, 8'd1, 10'h0, 1'b0);
            if (i == 254) expect_out("score_255", 2'd1, 1'b0, 1'b1, 8'd255, 8'd254, 10'h0, 1'b0);
        end
        pipe_x = 10'd640; step();
        expect_out("score_sat", 2'd1, 1'b0, 1'b1, 8'd255, 8'd255, 10'h0, 1'b0);

        bird_y = 10'd464; step();
        expect_out("floor_edge", 2'd1, 1'b0, 1'b1, 8'd255, 8'd255, 10'h0, 1'b0);
        bird_y = 10'd465; step();
        expect_out("floor_collide", 2'd2, 1'b0, 1'b0, 8'd255, 8'd255, 10'h0, 1'b0);

        bird_y = 10'd200;
        flap = 1'b1; step(); flap = 1'b0;
        expect_out("restart2", 2'd0, 1'b1, 1'b0, 8'd0, 8'd255, 10'h0, 1'b0);
        flap = 1'b1; step(); flap = 1'b0;
        expect_out("start3", 2'd1, 1'b0, 1'b1, 8'd0, 8'd255, 10'h0, 1'b0);

        @(posedge clk);
        #3 reset = 1'b0;
        expect_out("async_reset", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0, 10'h000, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        step(2);
        expect_out("post_reset", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0, 10'h000, 1'b1);
        step(2);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
